fsm_input_conditioner: RTL and testbench
========================================

Name: fsm_input_conditioner

Overview:
- Upstream stage of the basic FSM: turns two raw, asynchronous, possibly bouncy inputs into clean, synchronous, debounced levels.
- Outputs a and b connect straight to the FSM's a/b inputs on the same clock.
- One synchronizer plus one debounce state machine per channel, with one-cycle edge pulses for downstream logging.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples required to accept a level change; legal range 2..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width; derived localparam, not user-set.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserted while 0, released synchronously to clock by the system.
- raw_a  input  1  asynchronous raw input, channel A.
- raw_b  input  1  asynchronous raw input, channel B.
- a  output  1  debounced level, channel A (feeds the FSM's a).
- b  output  1  debounced level, channel B (feeds the FSM's b).
- a_edge  output  1  one-cycle pulse on any accepted change of a.
- b_edge  output  1  one-cycle pulse on any accepted change of b.

Behaviour:
- Reset (reset=0), taking effect immediately and asynchronously:
  - all synchronizer flops 0;
  - both channel FSMs in LOW;
  - counters 0;
  - a=b=0; a_edge=b_edge=0.
- Synchronizer: raw_x shifts through SYNC_STAGES flops. Only the last stage, s_x, is used downstream.
- Per-channel FSM has 4 states: LOW, CHK_H, HIGH, CHK_L.
  - LOW: s=1 -> CHK_H, cnt=1. Otherwise stay.
  - CHK_H:
    - s=0 -> LOW, cnt=0 (glitch rejected; output unchanged).
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, x=1, x_edge=1.
    - Otherwise cnt++.
  - HIGH / CHK_L: mirror of LOW / CHK_H with levels inverted. Accepted change sets x=0, x_edge=1.
- Output x is registered and equals 1 exactly in HIGH and CHK_L.
- x_edge is 1 only in the cycle after an accepted transition; otherwise 0.
- Latency: a clean step on raw_x between edges changes x on the (SYNC_STAGES+DEBOUNCE_CYCLES)th subsequent rising edge. Defaults: 6 edges.
- A pulse of fewer than DEBOUNCE_CYCLES synchronized samples never reaches x.
- A bounce inside a CHK state restarts the count from scratch. No partial credit is kept.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- Channels are fully independent. Simultaneous changes on raw_a and raw_b produce a_edge and b_edge in the same cycle.
- Reset asserted mid-count abandons the count. After release, raw inputs held high are re-qualified from LOW with full latency.

Optional Feature:
- Macro: FSM_INPUT_GLITCH_COUNT_EN.
- When defined:
  - Adds outputs glitch_cnt_a and glitch_cnt_b, each 8 bits.
  - Each counter increments on every CHK_x -> original-state abort.
  - Counters saturate at 255 and clear on reset.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fsm_input_pkg holds:
  - the state enum/localparams LOW=2'd0, CHK_H=2'd1, HIGH=2'd2, CHK_L=2'd3;
  - the default SYNC_STAGES and DEBOUNCE_CYCLES constants.
- Natural sub-module: debounce_channel, which holds the synchronizer, FSM, counter and optional glitch counter for one bit. The top instantiates it twice.

Test Plan:
- Reset held 3 cycles with raw_a=raw_b=1, then released -> a=b=0 during reset; a and b rise together on edge 6 after release; a_edge=b_edge=1 for exactly that one cycle.
- raw_a high for 2 cycles then low (defaults) -> a stays 0 and a_edge never pulses. With the macro defined, glitch_cnt_a becomes 1.
- raw_b toggles 1,0,1 every cycle, then holds 1 -> b rises exactly 6 edges after the final rising transition; no earlier edge pulse.
- Stable a=1, then raw_a low for 10 cycles -> a falls 6 edges after the change; a_edge pulses once; b is unaffected.
- Reset asserted asynchronously mid-CHK_H (cnt=2) between clock edges -> a, a_edge and cnt clear immediately, without waiting for a clock edge.
- With the macro defined, 300 rejected glitches on raw_a -> glitch_cnt_a saturates at 255 and stays there.

Source files
------------

// File: rtl/fsm_input_pkg.sv
// Shared types and defaults for the FSM input conditioner.
// Optional feature macro: FSM_INPUT_GLITCH_COUNT_EN (per-channel glitch counters).
package fsm_input_pkg;

   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
   localparam int unsigned GLITCH_W            = 8;

   // Bit 1 of the encoding is the debounced level (HIGH and CHK_L both read 1).
   typedef enum logic [1:0] {
      LOW   = 2'd0,
      CHK_H = 2'd1,
      HIGH  = 2'd2,
      CHK_L = 2'd3
   } chan_state_t;

endpackage

// File: rtl/fsm_input_conditioner_if.sv
// Raw inputs and conditioned outputs of the FSM input conditioner.
// Optional feature macro: FSM_INPUT_GLITCH_COUNT_EN adds the glitch counters.
interface fsm_input_conditioner_if;
   import fsm_input_pkg::*;

   logic                raw_a;
   logic                raw_b;
   logic                a;
   logic                b;
   logic                a_edge;
   logic                b_edge;
`ifdef FSM_INPUT_GLITCH_COUNT_EN
   logic [GLITCH_W-1:0] glitch_cnt_a;
   logic [GLITCH_W-1:0] glitch_cnt_b;
`endif

   // Upstream side: supplies raw inputs, consumes conditioned levels.
   modport master (
      output raw_a, raw_b,
      input  a, b, a_edge, b_edge
`ifdef FSM_INPUT_GLITCH_COUNT_EN
      , input glitch_cnt_a, glitch_cnt_b
`endif
   );

   // Conditioner side.
   modport slave (
      input  raw_a, raw_b,
      output a, b, a_edge, b_edge
`ifdef FSM_INPUT_GLITCH_COUNT_EN
      , output glitch_cnt_a, glitch_cnt_b
`endif
   );

endinterface

// File: rtl/fsm_input_conditioner_debounce_channel.sv
// One channel: synchronizer, debounce FSM, qualify counter, optional glitch counter.
// Optional feature macro: FSM_INPUT_GLITCH_COUNT_EN.
module debounce_channel
   import fsm_input_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                raw,
   output logic                level,
   output logic                pulse
`ifdef FSM_INPUT_GLITCH_COUNT_EN
   , output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   chan_state_t            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pulse_q, pulse_d;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Debounce state, counter and edge pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOW;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   // Next state: a mismatching sample in a CHK state drops all credit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      unique case (state_q)
         LOW: begin
            if (s) begin
               state_d = CHK_H;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_H: begin
            if (!s) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s) begin
               state_d = CHK_L;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_L: begin
            if (s) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = LOW;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Level is bit 1 of the registered state.
   assign level = state_q[1];
   assign pulse = pulse_q;

`ifdef FSM_INPUT_GLITCH_COUNT_EN
   logic                abort_c;
   logic [GLITCH_W-1:0] glitch_q;

   assign abort_c = ((state_q == CHK_H) && !s) || ((state_q == CHK_L) && s);

   // Count aborted qualifications, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           glitch_q <= '0;
      else if (abort_c && (glitch_q != '1)) glitch_q <= glitch_q + GLITCH_W'(1);
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: rtl/fsm_input_conditioner.sv
// Conditions two raw asynchronous inputs into debounced levels and edge pulses.
// Optional feature macro: FSM_INPUT_GLITCH_COUNT_EN (glitch_cnt_a / glitch_cnt_b).
module fsm_input_conditioner
   import fsm_input_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   fsm_input_conditioner_if.slave  bus
);

   // Channel A.
   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_chan_a (
      .clk        (clock),
      .rst_n      (reset),
      .raw        (bus.raw_a),
      .level      (bus.a),
      .pulse      (bus.a_edge)
`ifdef FSM_INPUT_GLITCH_COUNT_EN
      , .glitch_cnt (bus.glitch_cnt_a)
`endif
   );

   // Channel B.
   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_chan_b (
      .clk        (clock),
      .rst_n      (reset),
      .raw        (bus.raw_b),
      .level      (bus.b),
      .pulse      (bus.b_edge)
`ifdef FSM_INPUT_GLITCH_COUNT_EN
      , .glitch_cnt (bus.glitch_cnt_b)
`endif
   );

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Directed bench for fsm_input_conditioner at default parameters.
// Observed vector order is {a, b, a_edge, b_edge}.
module tb_fsm_input_conditioner;
   import fsm_input_pkg::*;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   logic [3:0] obs;
   logic [3:0] exp_v;

   fsm_input_conditioner_if bus ();

   fsm_input_conditioner dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      obs = {bus.a, bus.b, bus.a_edge, bus.b_edge};
   endtask

   task automatic test_reset();
      bus.raw_a = 1'b1;
      bus.raw_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold cyc %0d got %b want 0000", i, obs);
         end
      end
      @(negedge clock);
      reset = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_v = (i < 6) ? 4'b0000 : ((i == 6) ? 4'b1111 : 4'b1100);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_release edge %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_fall_a();
      @(negedge clock);
      bus.raw_a = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp_v = (i < 6) ? 4'b1100 : ((i == 6) ? 4'b0110 : 4'b0100);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL fall_a edge %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_glitch_a();
      @(negedge clock);
      bus.raw_a = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 2) bus.raw_a = 1'b0;
         checks++;
         if (obs !== 4'b0100) begin
            errors++;
            $display("FAIL glitch_a edge %0d got %b want 0100", i, obs);
         end
      end
`ifdef FSM_INPUT_GLITCH_COUNT_EN
      checks++;
      if (bus.glitch_cnt_a !== 8'd1) begin
         errors++;
         $display("FAIL glitch_cnt_a_one got %0d want 1", bus.glitch_cnt_a);
      end
`endif
   endtask

   task automatic test_bounce_b();
      @(negedge clock);
      bus.raw_b = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_v = (i < 6) ? 4'b0100 : ((i == 6) ? 4'b0001 : 4'b0000);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL fall_b edge %0d got %b want %b", i, obs, exp_v);
         end
      end
      @(negedge clock);
      bus.raw_b = 1'b1;
      tick();
      checks++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL bounce_b step1 got %b want 0000", obs);
      end
      @(negedge clock);
      bus.raw_b = 1'b0;
      tick();
      checks++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL bounce_b step2 got %b want 0000", obs);
      end
      @(negedge clock);
      bus.raw_b = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_v = (i < 6) ? 4'b0000 : ((i == 6) ? 4'b0101 : 4'b0100);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL bounce_b edge %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clock);
      bus.raw_a = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (obs !== 4'b0100) begin
            errors++;
            $display("FAIL pre_reset edge %0d got %b want 0100", i, obs);
         end
      end
      checks++;
      if (dut.u_chan_a.cnt_q !== 2'd2 || dut.u_chan_a.state_q !== CHK_H) begin
         errors++;
         $display("FAIL mid_chk_h got cnt %0d state %0d want cnt 2 state 1",
                  dut.u_chan_a.cnt_q, dut.u_chan_a.state_q);
      end
      #2;
      reset = 1'b0;
      #1;
      obs = {bus.a, bus.b, bus.a_edge, bus.b_edge};
      checks++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset_out got %b want 0000", obs);
      end
      checks++;
      if (dut.u_chan_a.cnt_q !== 2'd0 || dut.u_chan_a.state_q !== LOW) begin
         errors++;
         $display("FAIL async_reset_cnt got cnt %0d state %0d want cnt 0 state 0",
                  dut.u_chan_a.cnt_q, dut.u_chan_a.state_q);
      end
      tick();
      checks++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset_hold got %b want 0000", obs);
      end
      @(negedge clock);
      reset = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_v = (i < 6) ? 4'b0000 : ((i == 6) ? 4'b1111 : 4'b1100);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL requalify edge %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_simultaneous();
      @(negedge clock);
      bus.raw_a = 1'b0;
      bus.raw_b = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_v = (i < 6) ? 4'b1100 : ((i == 6) ? 4'b0011 : 4'b0000);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL simultaneous edge %0d got %b want %b", i, obs, exp_v);
         end
      end
   endtask

`ifdef FSM_INPUT_GLITCH_COUNT_EN
   task automatic test_glitch_saturate();
      for (int n = 1; n <= 300; n++) begin
         @(negedge clock);
         bus.raw_a = 1'b1;
         @(negedge clock);
         bus.raw_a = 1'b0;
         repeat (3) @(posedge clock);
         #1;
         if (n == 200 || n == 255 || n == 300) begin
            exp_v = {4'b0000};
            checks++;
            if (bus.glitch_cnt_a !== ((n == 200) ? 8'd200 : 8'd255)) begin
               errors++;
               $display("FAIL glitch_sat n %0d got %0d want %0d", n,
                        bus.glitch_cnt_a, (n == 200) ? 200 : 255);
            end
         end
      end
      obs = {bus.a, bus.b, bus.a_edge, bus.b_edge};
      checks++;
      if (obs !== 4'b0000 || bus.glitch_cnt_b !== 8'd0) begin
         errors++;
         $display("FAIL glitch_sat_side got %b cnt_b %0d want 0000 cnt_b 0",
                  obs, bus.glitch_cnt_b);
      end
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      bus.raw_a = 1'b0;
      bus.raw_b = 1'b0;
      test_reset();
      test_fall_a();
      test_glitch_a();
      test_bounce_b();
      test_async_reset();
      test_simultaneous();
`ifdef FSM_INPUT_GLITCH_COUNT_EN
      test_glitch_saturate();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
